// File: rtl/bus_arbiter_if.sv
// Handshake bundle between the bus arbiter and its initiators, split target and datapath.
// The arbiter connects through the slave modport; the bus side drives through master.
interface bus_arbiter_if;
  logic       init1_req;
  logic       init2_req;
  logic       split_target_req;
  logic       split_ack_in;
  logic       txn_done;
  logic       init1_grant;
  logic       init2_grant;
  logic       split_target_grant;
  logic [1:0] bus_owner;
  logic       split_pending;
  logic       protocol_err;

  modport slave (
    input  init1_req, init2_req, split_target_req, split_ack_in, txn_done,
    output init1_grant, init2_grant, split_target_grant, bus_owner,
           split_pending, protocol_err
  );

  modport master (
    output init1_req, init2_req, split_target_req, split_ack_in, txn_done,
    input  init1_grant, init2_grant, split_target_grant, bus_owner,
           split_pending, protocol_err
  );
endinterface

// File: rtl/bus_arbiter.sv
// Two-initiator bus arbiter with split-transaction parking and split-target data return.
// All outputs are registered copies of the next-state decode.
module bus_arbiter #(
  parameter bit ROUND_ROBIN = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  bus_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, GRANT1, GRANT2, SPLIT_RET} state_e;

  // Initiator index: 0 = init1, 1 = init2.
  localparam logic INIT1 = 1'b0;
  localparam logic INIT2 = 1'b1;

  state_e     state_q, state_d;
  logic       split_owner_q, split_owner_d;
  logic       last_grant_q, last_grant_d;
  logic       split_pending_q, split_pending_d;
  logic       protocol_err_q, protocol_err_d;
  logic       init1_grant_q, init1_grant_d;
  logic       init2_grant_q, init2_grant_d;
  logic       split_grant_q, split_grant_d;
  logic [1:0] bus_owner_q, bus_owner_d;

  logic elig1, elig2;
  logic served, served_req;

  assign elig1 = bus.init1_req && !(split_pending_q && split_owner_q == INIT1);
  assign elig2 = bus.init2_req && !(split_pending_q && split_owner_q == INIT2);

  assign served     = (state_q == GRANT2) ? INIT2 : INIT1;
  assign served_req = (state_q == GRANT2) ? bus.init2_req : bus.init1_req;

  always_comb begin
    // NOTE: every variable gets a default first so no path infers a latch.
    state_d         = state_q;
    split_owner_d   = split_owner_q;
    last_grant_d    = last_grant_q;
    split_pending_d = split_pending_q;
    protocol_err_d  = protocol_err_q;

    unique case (state_q)
      IDLE: begin
        if (bus.split_ack_in || bus.txn_done) protocol_err_d = 1'b1;
        if (split_pending_q && bus.split_target_req) begin
          state_d = SPLIT_RET;
        end else if (elig1 && elig2) begin
          if (ROUND_ROBIN) state_d = (last_grant_q == INIT1) ? GRANT2 : GRANT1;
          else             state_d = GRANT1;
        end else if (elig1) begin
          state_d = GRANT1;
        end else if (elig2) begin
          state_d = GRANT2;
        end
      end

      GRANT1, GRANT2: begin
        if (bus.split_ack_in && !split_pending_q) begin
          // A valid deferral outranks a simultaneous txn_done.
          state_d         = IDLE;
          split_pending_d = 1'b1;
          split_owner_d   = served;
        end else begin
          // A second deferral is only flagged; it never re-parks anyone.
          if (bus.split_ack_in) protocol_err_d = 1'b1;
          if (bus.txn_done || !served_req) state_d = IDLE;
        end
      end

      SPLIT_RET: begin
        if (bus.split_ack_in) protocol_err_d = 1'b1;
        if (bus.txn_done) begin
          state_d         = IDLE;
          split_pending_d = 1'b0;
        end
      end

      default: state_d = IDLE;
    endcase

    if (state_d == GRANT1 && state_q != GRANT1) last_grant_d = INIT1;
    if (state_d == GRANT2 && state_q != GRANT2) last_grant_d = INIT2;
  end

  // Output decode of the next state, so the flops present it the edge after a decision.
  always_comb begin
    init1_grant_d = (state_d == GRANT1);
    init2_grant_d = (state_d == GRANT2);
    split_grant_d = (state_d == SPLIT_RET);
    unique case (state_d)
      GRANT1:    bus_owner_d = 2'd1;
      GRANT2:    bus_owner_d = 2'd2;
      SPLIT_RET: bus_owner_d = (split_owner_d == INIT2) ? 2'd2 : 2'd1;
      default:   bus_owner_d = 2'd0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      split_owner_q   <= INIT1;
      last_grant_q    <= INIT2;
      split_pending_q <= 1'b0;
      protocol_err_q  <= 1'b0;
      init1_grant_q   <= 1'b0;
      init2_grant_q   <= 1'b0;
      split_grant_q   <= 1'b0;
      bus_owner_q     <= 2'd0;
    end else begin
      state_q         <= state_d;
      split_owner_q   <= split_owner_d;
      last_grant_q    <= last_grant_d;
      split_pending_q <= split_pending_d;
      protocol_err_q  <= protocol_err_d;
      init1_grant_q   <= init1_grant_d;
      init2_grant_q   <= init2_grant_d;
      split_grant_q   <= split_grant_d;
      bus_owner_q     <= bus_owner_d;
    end
  end

  assign bus.init1_grant        = init1_grant_q;
  assign bus.init2_grant        = init2_grant_q;
  assign bus.split_target_grant = split_grant_q;
  assign bus.bus_owner          = bus_owner_q;
  assign bus.split_pending      = split_pending_q;
  assign bus.protocol_err       = protocol_err_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: a round-robin instance and a fixed-priority instance.
// Observed vector layout: {init1_grant, init2_grant, split_target_grant, bus_owner[1:0], split_pending, protocol_err}.
module tb_bus_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  bus_arbiter_if rr_if ();
  bus_arbiter_if fp_if ();

  bus_arbiter #(.ROUND_ROBIN(1'b1)) dut_rr (.clk(clk), .rst_n(rst_n), .bus(rr_if.slave));
  bus_arbiter #(.ROUND_ROBIN(1'b0)) dut_fp (.clk(clk), .rst_n(rst_n), .bus(fp_if.slave));

  function automatic logic [6:0] obs_rr();
    return {rr_if.init1_grant, rr_if.init2_grant, rr_if.split_target_grant,
            rr_if.bus_owner, rr_if.split_pending, rr_if.protocol_err};
  endfunction

  function automatic logic [6:0] obs_fp();
    return {fp_if.init1_grant, fp_if.init2_grant, fp_if.split_target_grant,
            fp_if.bus_owner, fp_if.split_pending, fp_if.protocol_err};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    rr_if.init1_req = 0; rr_if.init2_req = 0; rr_if.split_target_req = 0;
    rr_if.split_ack_in = 0; rr_if.txn_done = 0;
    fp_if.init1_req = 0; fp_if.init2_req = 0; fp_if.split_target_req = 0;
    fp_if.split_ack_in = 0; fp_if.txn_done = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (obs_rr() !== 7'b0000000) begin
      bad++; $display("FAIL reset_rr: got %b want %b", obs_rr(), 7'b0000000);
    end
    total++;
    if (obs_fp() !== 7'b0000000) begin
      bad++; $display("FAIL reset_fp: got %b want %b", obs_fp(), 7'b0000000);
    end
  endtask

  task automatic test_round_robin();
    logic [6:0] exp;
    do_reset();
    rr_if.init1_req = 1; rr_if.init2_req = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      exp = (i % 2 == 0) ? 7'b1000100 : 7'b0101000;
      total++;
      if (obs_rr() !== exp) begin
        bad++; $display("FAIL rr_grant%0d: got %b want %b", i, obs_rr(), exp);
      end
      step(); step();
      rr_if.txn_done = 1;
      step();
      rr_if.txn_done = 0;
      if (i == 3) begin rr_if.init1_req = 0; rr_if.init2_req = 0; end
      total++;
      if (obs_rr() !== 7'b0000000) begin
        bad++; $display("FAIL rr_turnaround%0d: got %b want %b", i, obs_rr(), 7'b0000000);
      end
    end
    step();
  endtask

  task automatic test_fixed_priority();
    do_reset();
    fp_if.init1_req = 1; fp_if.init2_req = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (obs_fp() !== 7'b1000100) begin
        bad++; $display("FAIL fp_grant%0d: got %b want %b", i, obs_fp(), 7'b1000100);
      end
      step();
      fp_if.txn_done = 1;
      step();
      fp_if.txn_done = 0;
      if (i == 2) begin fp_if.init1_req = 0; fp_if.init2_req = 0; end
      total++;
      if (obs_fp() !== 7'b0000000) begin
        bad++; $display("FAIL fp_turnaround%0d: got %b want %b", i, obs_fp(), 7'b0000000);
      end
    end
    step();
  endtask

  task automatic test_basic_grant();
    do_reset();
    rr_if.init1_req = 1;
    step();
    total++;
    if (obs_rr() !== 7'b1000100) begin
      bad++; $display("FAIL basic_grant: got %b want %b", obs_rr(), 7'b1000100);
    end
    step();
    rr_if.txn_done = 1;
    step();
    rr_if.txn_done = 0; rr_if.init1_req = 0;
    total++;
    if (obs_rr() !== 7'b0000000) begin
      bad++; $display("FAIL basic_release: got %b want %b", obs_rr(), 7'b0000000);
    end
    step();
    total++;
    if (obs_rr() !== 7'b0000000) begin
      bad++; $display("FAIL basic_idle: got %b want %b", obs_rr(), 7'b0000000);
    end
  endtask

  task automatic test_split_flow();
    logic [6:0] exp [8] = '{7'b0000010, 7'b1000110, 7'b1000110, 7'b0000010,
                            7'b0011010, 7'b0011010, 7'b0000000, 7'b0101000};
    do_reset();
    rr_if.init2_req = 1;
    step();
    total++;
    if (obs_rr() !== 7'b0101000) begin
      bad++; $display("FAIL split_grant2: got %b want %b", obs_rr(), 7'b0101000);
    end
    for (int s = 0; s < 8; s++) begin
      case (s)
        0: rr_if.split_ack_in = 1;
        1: rr_if.init1_req = 1;
        2: rr_if.split_target_req = 1;
        3: rr_if.txn_done = 1;
        5: rr_if.split_target_req = 0;
        6: rr_if.txn_done = 1;
        default: ;
      endcase
      step();
      rr_if.split_ack_in = 0; rr_if.txn_done = 0;
      if (s == 3) rr_if.init1_req = 0;
      total++;
      if (obs_rr() !== exp[s]) begin
        bad++; $display("FAIL split_step%0d: got %b want %b", s, obs_rr(), exp[s]);
      end
    end
    rr_if.txn_done = 1;
    step();
    rr_if.txn_done = 0; rr_if.init2_req = 0;
    total++;
    if (obs_rr() !== 7'b0000000) begin
      bad++; $display("FAIL split_final: got %b want %b", obs_rr(), 7'b0000000);
    end
  endtask

  task automatic test_parked_masking();
    int leaks = 0;
    do_reset();
    rr_if.init2_req = 1;
    step();
    rr_if.split_ack_in = 1;
    step();
    rr_if.split_ack_in = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (obs_rr() !== 7'b0000010) leaks++;
    end
    total++;
    if (leaks !== 0) begin
      bad++; $display("FAIL parked_mask: got %0d bad cycles want 0", leaks);
    end
    rr_if.split_target_req = 1;
    step();
    total++;
    if (obs_rr() !== 7'b0011010) begin
      bad++; $display("FAIL parked_return: got %b want %b", obs_rr(), 7'b0011010);
    end
    rr_if.txn_done = 1; rr_if.split_target_req = 0;
    step();
    rr_if.txn_done = 0;
    total++;
    if (obs_rr() !== 7'b0000000) begin
      bad++; $display("FAIL parked_done: got %b want %b", obs_rr(), 7'b0000000);
    end
    step();
    total++;
    if (obs_rr() !== 7'b0101000) begin
      bad++; $display("FAIL parked_regrant: got %b want %b", obs_rr(), 7'b0101000);
    end
    rr_if.txn_done = 1;
    step();
    rr_if.txn_done = 0; rr_if.init2_req = 0;
    step();
  endtask

  task automatic test_errors();
    do_reset();
    rr_if.txn_done = 1;
    step();
    rr_if.txn_done = 0;
    total++;
    if (obs_rr() !== 7'b0000001) begin
      bad++; $display("FAIL err_idle_done: got %b want %b", obs_rr(), 7'b0000001);
    end
    do_reset();
    rr_if.init2_req = 1;
    step();
    rr_if.split_ack_in = 1;
    step();
    rr_if.split_ack_in = 0; rr_if.init2_req = 0; rr_if.init1_req = 1;
    total++;
    if (obs_rr() !== 7'b0000010) begin
      bad++; $display("FAIL err_first_split: got %b want %b", obs_rr(), 7'b0000010);
    end
    step();
    rr_if.split_ack_in = 1;
    step();
    rr_if.split_ack_in = 0;
    total++;
    if ((obs_rr() & 7'b0000011) !== 7'b0000011) begin
      bad++; $display("FAIL err_double_split: got %b want xxxxx11", obs_rr());
    end
    rr_if.init1_req = 0;
    repeat (5) step();
    total++;
    if (obs_rr() !== 7'b0000011) begin
      bad++; $display("FAIL err_sticky: got %b want %b", obs_rr(), 7'b0000011);
    end
  endtask

  task automatic test_reset_mid_op();
    do_reset();
    rr_if.init1_req = 1;
    step();
    rr_if.split_ack_in = 1;
    step();
    rr_if.split_ack_in = 0; rr_if.init2_req = 1;
    step();
    total++;
    if (obs_rr() !== 7'b0101010) begin
      bad++; $display("FAIL midrst_grant2: got %b want %b", obs_rr(), 7'b0101010);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (obs_rr() !== 7'b0000000) begin
      bad++; $display("FAIL midrst_async: got %b want %b", obs_rr(), 7'b0000000);
    end
    #2 rst_n = 1'b1;
    step();
    total++;
    if (obs_rr() !== 7'b1000100) begin
      bad++; $display("FAIL midrst_init1_first: got %b want %b", obs_rr(), 7'b1000100);
    end
    clear_inputs();
    step();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_round_robin();
    test_fixed_priority();
    test_basic_grant();
    test_split_flow();
    test_parked_masking();
    test_errors();
    test_reset_mid_op();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
